// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//  Shared types and defaults for the memory bus arbiter that splits one
//  SRAM-like bus between the fetch port and the data port of the core.
//
//  Contents
//   arb_state_e : IDLE / ADDR / WAIT bus-side sequencer states
//   arb_grant_e : which port owns the transaction in flight
//   DEF_*       : default widths used by the arbiter parameters
//   BE_W        : byte-enable width for the default data width
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_PERF_W = 32;
    localparam int BE_W       = DEF_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_grant_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//  Shares one SRAM-like memory bus between the instruction-fetch port and the
//  data-access port of the core. One transaction is in flight at a time and
//  the data port wins when both ports want the bus. A single combinational
//  stall is held until every port requested in the current pipeline cycle
//  has completed.
//
//  Optional feature: define ARB_PERF_EN to add three wrapping performance
//  counters exposed on perf_cnt = {stall_cyc, data_txn, inst_txn}.
//
//  Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   inst_req/inst_addr            fetch request, held until stall falls
//   inst_rdata                    registered fetched word
//   data_req/data_wr/data_wen     load/store request, held until stall falls
//   data_addr/data_wdata          load/store address and store data
//   data_rdata                    registered load data
//   stall                         combinational pipeline stall
//   perf_cnt                      performance counters (ARB_PERF_EN only)
//   bus_req/bus_wr/bus_wen        bus address-phase request and attributes
//   bus_addr/bus_wdata            bus address and write data
//   bus_addr_ok/bus_data_ok       bus handshakes
//   bus_rdata                     bus read data, valid with bus_data_ok
// ---------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int PERF_W = DEF_PERF_W
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic [DATA_W-1:0]     inst_rdata,

    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [DATA_W/8-1:0]   data_wen,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic [DATA_W-1:0]     data_rdata,

    output logic                  stall,
`ifdef ARB_PERF_EN
    output logic [3*PERF_W-1:0]   perf_cnt,
`endif

    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [DATA_W/8-1:0]   bus_wen,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam int WEN_W = DATA_W / 8;

    arb_state_e         state_q, state_d;
    arb_grant_e         grant_q, grant_d;
    logic               i_done_q, i_done_d;
    logic               d_done_q, d_done_d;
    logic               bus_wr_q, bus_wr_d;
    logic [WEN_W-1:0]   bus_wen_q, bus_wen_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]  inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]  data_rdata_q, data_rdata_d;

    logic               complete;
    logic               pending_i, pending_d;
    logic               i_done_eff, d_done_eff;
    logic               stall_w;

    // Requests not yet served in this pipeline cycle, as seen when idle.
    assign pending_i = inst_req & ~i_done_q;
    assign pending_d = data_req & ~d_done_q;

    // State register plus the registered bus fields, grant and read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= GNT_I;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_wen_q    <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            bus_wr_q     <= bus_wr_d;
            bus_wen_q    <= bus_wen_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Next-state logic. The bus fields are captured only on the IDLE->ADDR
    // transition so they stay stable for the whole address phase.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        bus_wr_d    = bus_wr_q;
        bus_wen_d   = bus_wen_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        complete    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pending_d) begin
                    state_d     = ADDR;
                    grant_d     = GNT_D;
                    bus_wr_d    = data_wr;
                    bus_wen_d   = data_wr ? data_wen : '0;
                    bus_addr_d  = data_addr;
                    bus_wdata_d = data_wdata;
                end else if (pending_i) begin
                    state_d     = ADDR;
                    grant_d     = GNT_I;
                    bus_wr_d    = 1'b0;
                    bus_wen_d   = '0;
                    bus_addr_d  = inst_addr;
                    bus_wdata_d = '0;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus_data_ok) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Done flags include the completing transaction in the same cycle so the
    // stall drops in the completion cycle rather than one cycle later. Once
    // stall is low the pipeline advances and both flags start fresh.
    always_comb begin
        i_done_eff   = i_done_q | (complete & (grant_q == GNT_I));
        d_done_eff   = d_done_q | (complete & (grant_q == GNT_D));
        stall_w      = (inst_req & ~i_done_eff) | (data_req & ~d_done_eff);
        i_done_d     = stall_w ? i_done_eff : 1'b0;
        d_done_d     = stall_w ? d_done_eff : 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        if (complete && !bus_wr_q) begin
            if (grant_q == GNT_I) begin
                inst_rdata_d = bus_rdata;
            end else begin
                data_rdata_d = bus_rdata;
            end
        end
    end

    // bus_req comes straight from the state so an asynchronous reset drops
    // it immediately, even mid-transaction.
    assign bus_req    = (state_q == ADDR);
    assign bus_wr     = bus_wr_q;
    assign bus_wen    = bus_wen_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign stall      = stall_w;

`ifdef ARB_PERF_EN
    logic [PERF_W-1:0] inst_txn_q, data_txn_q, stall_cyc_q;

    // Free-running wrapping counters of completions and stalled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_txn_q  <= '0;
            data_txn_q  <= '0;
            stall_cyc_q <= '0;
        end else begin
            if (complete && (grant_q == GNT_I)) begin
                inst_txn_q <= inst_txn_q + 1'b1;
            end
            if (complete && (grant_q == GNT_D)) begin
                data_txn_q <= data_txn_q + 1'b1;
            end
            if (stall_w) begin
                stall_cyc_q <= stall_cyc_q + 1'b1;
            end
        end
    end

    assign perf_cnt = {stall_cyc_q, data_txn_q, inst_txn_q};
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//  Scoreboard bench for mem_bus_arbiter. Each pipeline step pushes the bus
//  transactions it must cause (data first, then fetch) into a queue; a
//  monitor pops them as the DUT presents address phases, tracks the stall
//  each cycle and checks the read data when a step finishes. A randomised
//  bus responder supplies handshakes and read words.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PW = 32;
    localparam int WW = BE_W;

    typedef struct {
        logic          wr;
        logic [WW-1:0] wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } busTxn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inst_req = 1'b0;
    logic [AW-1:0] inst_addr = '0;
    logic [DW-1:0] inst_rdata;
    logic          data_req = 1'b0;
    logic          data_wr = 1'b0;
    logic [WW-1:0] data_wen = '0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic [DW-1:0] data_rdata;
    logic          stall;
    logic          bus_req;
    logic          bus_wr;
    logic [WW-1:0] bus_wen;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok = 1'b0;
    logic          bus_data_ok = 1'b0;
    logic [DW-1:0] bus_rdata = '0;
`ifdef ARB_PERF_EN
    logic [3*PW-1:0] perf_cnt;
`endif

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PERF_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_wen    (data_wen),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .stall       (stall),
`ifdef ARB_PERF_EN
        .perf_cnt    (perf_cnt),
`endif
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_wen     (bus_wen),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    int vectors = 0;
    int miscompares = 0;

    busTxn_t       expBus[$];
    logic [DW-1:0] rdWords[$];

    bit            manual = 1'b1;
    logic          manAddrOk = 1'b0;
    logic          manDataOk = 1'b0;
    logic [DW-1:0] manRdata = '0;
    int            fixA = 0;
    int            fixD = 0;

    int            stepNeed = 0;
    int            stepDone = 0;
    bit            stepOpen = 1'b0;
    bit            stepInst = 1'b0;
    bit            stepData = 1'b0;
    bit            stepWr = 1'b0;
    int            nInst = 0;
    int            nData = 0;
    int            stallCyc = 0;
    logic [DW-1:0] expInst = '0;
    logic [DW-1:0] expData = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finishBench();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // Bus responder: drives handshakes on the falling edge with either fixed
    // or random address/data latencies; every data_ok returns a fresh word.
    initial begin
        int rPhase = 0;
        int rCnt = 0;
        int dLat = 0;
        forever begin
            @(negedge clk);
            if (manual) begin
                bus_addr_ok = manAddrOk;
                bus_data_ok = manDataOk;
                bus_rdata   = manRdata;
                rPhase      = 0;
                continue;
            end
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            if (rPhase == 0 && bus_req) begin
                rPhase = 1;
                rCnt   = (fixA >= 0) ? fixA : int'($urandom_range(0, 3));
                dLat   = (fixD >= 0) ? fixD : int'($urandom_range(0, 4));
            end
            if (rPhase == 1) begin
                if (rCnt == 0) begin
                    bus_addr_ok = 1'b1;
                    if (dLat == 0) begin
                        bus_data_ok = 1'b1;
                        bus_rdata   = $urandom;
                        rdWords.push_back(bus_rdata);
                        rPhase      = 0;
                    end else begin
                        rPhase = 2;
                        rCnt   = dLat - 1;
                    end
                end else begin
                    rCnt--;
                end
            end else if (rPhase == 2) begin
                if (rCnt == 0) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = $urandom;
                    rdWords.push_back(bus_rdata);
                    rPhase      = 0;
                end else begin
                    rCnt--;
                end
            end
        end
    end

    // Monitor: checks bus fields against the scoreboard, the stall against
    // the count of outstanding transactions, and read data after each step.
    initial begin
        bit            inWait = 1'b0;
        bit            prevDataOk = 1'b0;
        bit            rdPending = 1'b0;
        bit            expStall;
        busTxn_t       t;
        logic [DW-1:0] w;
        forever begin
            @(negedge clk);
            #2;
            if (manual) begin
                inWait     = 1'b0;
                prevDataOk = 1'b0;
                rdPending  = 1'b0;
                continue;
            end
            if (inWait || prevDataOk) begin
                checkOutput("bus_req low in WAIT/IDLE gap", bus_req, 1'b0);
            end
            if (bus_req) begin
                if (expBus.size() == 0) begin
                    checkOutput("unexpected bus_req", bus_req, 1'b0);
                end else begin
                    t = expBus[0];
                    checkOutput("bus_wr", bus_wr, t.wr);
                    checkOutput("bus_wen", bus_wen, t.wen);
                    checkOutput("bus_addr", bus_addr, t.addr);
                    if (t.wr) checkOutput("bus_wdata", bus_wdata, t.wdata);
                    if (bus_addr_ok) void'(expBus.pop_front());
                end
            end
            if (bus_data_ok) stepDone++;
            expStall = (stepDone < stepNeed);
            checkOutput("stall", stall, expStall);
            if (expStall) stallCyc++;
            if (bus_req && bus_addr_ok && !bus_data_ok) inWait = 1'b1;
            if (bus_data_ok) inWait = 1'b0;
            prevDataOk = bus_data_ok;

            if (rdPending) begin
                checkOutput("inst_rdata", inst_rdata, expInst);
                checkOutput("data_rdata", data_rdata, expData);
                rdPending = 1'b0;
            end
            if (stepOpen && !expStall) begin
                checkOutput("bus txn count", rdWords.size(), stepNeed);
                checkOutput("unissued txns", expBus.size(), 0);
                if (stepData && rdWords.size() > 0) begin
                    w = rdWords.pop_front();
                    if (!stepWr) expData = w;
                end
                if (stepInst && rdWords.size() > 0) begin
                    w = rdWords.pop_front();
                    expInst = w;
                end
                rdWords.delete();
                expBus.delete();
                rdPending = 1'b1;
                stepOpen  = 1'b0;
            end
        end
    end

    // One pipeline step: hold the requests until stall falls (bounded).
    task automatic applyStimulus(input bit iReq, input bit dReq, input bit wr,
                                 input logic [WW-1:0] wen, input logic [AW-1:0] iAddr,
                                 input logic [AW-1:0] dAddr, input logic [DW-1:0] wdata);
        busTxn_t t;
        bit      finished = 1'b0;
        @(negedge clk);
        inst_req   = iReq;
        inst_addr  = iAddr;
        data_req   = dReq;
        data_wr    = wr;
        data_wen   = wen;
        data_addr  = dAddr;
        data_wdata = wdata;
        if (dReq) begin
            t.wr = wr; t.wen = wr ? wen : '0; t.addr = dAddr; t.wdata = wdata;
            expBus.push_back(t);
        end
        if (iReq) begin
            t.wr = 1'b0; t.wen = '0; t.addr = iAddr; t.wdata = '0;
            expBus.push_back(t);
        end
        stepNeed = int'(iReq) + int'(dReq);
        stepDone = 0;
        stepInst = iReq;
        stepData = dReq;
        stepWr   = wr;
        stepOpen = 1'b1;
        nInst   += int'(iReq);
        nData   += int'(dReq);
        for (int c = 0; c < 300; c++) begin
            #3;
            if (!stall) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL step timeout: stall still %0b after 300 cycles", stall);
            finishBench();
        end
    endtask

    task automatic waitBusReq(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (bus_req) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit seen;
        #12;
        checkOutput("reset bus_req", bus_req, 1'b0);
        checkOutput("reset bus_wr", bus_wr, 1'b0);
        checkOutput("reset bus_wen", bus_wen, '0);
        checkOutput("reset bus_addr", bus_addr, '0);
        checkOutput("reset bus_wdata", bus_wdata, '0);
        checkOutput("reset inst_rdata", inst_rdata, '0);
        checkOutput("reset data_rdata", data_rdata, '0);
        checkOutput("reset stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1 manual = 1'b0;

        // Zero-wait bus directed cases: fetch only, fetch+load, store.
        fixA = 0; fixD = 0;
        applyStimulus(1, 0, 0, 4'h0, 32'hBFC0_0000, 32'h0, 32'h0);
        applyStimulus(1, 1, 0, 4'hF, 32'hBFC0_0004, 32'h8000_1000, 32'h0);
        applyStimulus(1, 1, 1, 4'b0011, 32'hBFC0_0008, 32'h8000_1004, 32'h1234_5678);
        applyStimulus(0, 1, 1, 4'b0011, 32'h0, 32'h8000_1008, 32'h1234_5678);

        // Slow bus: addr_ok after 3 cycles, data_ok 4 cycles later.
        fixA = 3; fixD = 4;
        applyStimulus(1, 1, 0, 4'h0, 32'hBFC0_000C, 32'h8000_2000, 32'h0);

        // Random traffic with random latencies, including empty steps.
        fixA = -1; fixD = -1;
        for (int i = 0; i < 60; i++) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                          4'($urandom_range(1, 15)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                          {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom);
        end
        applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #3;
`ifdef ARB_PERF_EN
        checkOutput("perf inst_txn", perf_cnt[PW-1:0], nInst);
        checkOutput("perf data_txn", perf_cnt[2*PW-1:PW], nData);
        checkOutput("perf stall_cyc", perf_cnt[3*PW-1:2*PW], stallCyc);
`endif
        manual = 1'b1;

        // Reset in the address phase must drop bus_req asynchronously.
        @(negedge clk);
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0100;
        waitBusReq(seen);
        checkOutput("bus_req raised for fetch", seen, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("async reset drops bus_req in ADDR", bus_req, 1'b0);
        checkOutput("reset clears inst_rdata", inst_rdata, '0);
        checkOutput("reset clears data_rdata", data_rdata, '0);
        @(negedge clk);
        #1 rst = 1'b1;

        // Reach WAIT, then reset; the late data_ok must not touch rdata.
        waitBusReq(seen);
        checkOutput("bus_req raised again", seen, 1'b1);
        manAddrOk = 1'b1;
        @(negedge clk);
        #1 manAddrOk = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("bus_req low in WAIT", bus_req, 1'b0);
        checkOutput("stall held in WAIT", stall, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("bus_req after reset in WAIT", bus_req, 1'b0);
        checkOutput("stall follows inst_req in reset", stall, 1'b1);
        inst_req = 1'b0;
        #1;
        checkOutput("stall low without requests", stall, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        manDataOk = 1'b1;
        manRdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        #1 manDataOk = 1'b0;
        @(negedge clk);
        #2;
        checkOutput("late data_ok inst_rdata", inst_rdata, '0);
        checkOutput("late data_ok data_rdata", data_rdata, '0);
        checkOutput("late data_ok bus_req", bus_req, 1'b0);
        checkOutput("late data_ok stall", stall, 1'b0);
        finishBench();
    end

    initial begin
        #500000;
        vectors++;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        finishBench();
    end

endmodule
